// File: rtl/dma_desc_writeback_if.sv
// Descriptor write-back bus bundle.
// Groups the show-ahead write-back FIFO read side and the Avalon-MM
// burst-write master into one interface.
//   master : the write-back engine (pops the FIFO, drives Avalon writes)
//   slave  : the FIFO/memory side (supplies entries, drives waitrequest)
// Handshake rules:
//   FIFO   : rddata is valid whenever fifo_empty==0. A pop consumes the
//            head on the rising edge where fifo_rd==1. The FIFO is never
//            popped while empty.
//   Avalon : a beat is accepted on the rising edge where write==1 and
//            waitrequest==0. While waitrequest==1 the master holds addr,
//            bcount and wrdata stable.
interface dma_desc_writeback_if;
  logic        dma_desc_wb_fifo_empty;
  logic        dma_desc_wb_fifo_rd;
  logic [95:0] dma_desc_wb_fifo_rddata;
  logic        dma_desc_wb_write;
  logic [31:0] dma_desc_wb_addr;
  logic [3:0]  dma_desc_wb_bcount;
  logic [31:0] dma_desc_wb_wrdata;
  logic        dma_desc_wb_waitrequest;

  modport master (
    input  dma_desc_wb_fifo_empty,
    output dma_desc_wb_fifo_rd,
    input  dma_desc_wb_fifo_rddata,
    output dma_desc_wb_write,
    output dma_desc_wb_addr,
    output dma_desc_wb_bcount,
    output dma_desc_wb_wrdata,
    input  dma_desc_wb_waitrequest
  );

  modport slave (
    output dma_desc_wb_fifo_empty,
    input  dma_desc_wb_fifo_rd,
    output dma_desc_wb_fifo_rddata,
    input  dma_desc_wb_write,
    input  dma_desc_wb_addr,
    input  dma_desc_wb_bcount,
    input  dma_desc_wb_wrdata,
    output dma_desc_wb_waitrequest
  );
endinterface

// File: rtl/dma_desc_writeback.sv
// Descriptor write-back engine.
// Pops completion entries from the write-back FIFO and returns each
// descriptor to software with one two-beat Avalon burst: the actual byte
// count to word 6, then the status word with owned_by_hw cleared to word 7.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   csr_control_i        : bit0 = run
//   wb                   : FIFO read side + Avalon burst-write master
//   dma_desc_wb_irq_o    : one-cycle completion pulse (status irq bit set)
//   dma_desc_wb_count_o  : completed descriptor count, wraps
//   dma_desc_wb_busy_o   : high in every state except IDLE
//   dma_desc_wb_err_o    : sticky misaligned-descriptor flag
//   dbg_state_o          : current FSM state for observation
// All outputs are decoded from the state and latched-entry flops, so
// waitrequest never reaches an output combinationally.
module dma_desc_writeback #(
  parameter logic [31:0] WB_OFFSET = 32'h18,
  parameter int          OWN_BIT   = 31,
  parameter int          IRQ_BIT   = 30,
  parameter int          CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           csr_control_i,
  dma_desc_writeback_if.master  wb,
  output logic                  dma_desc_wb_irq_o,
  output logic [CNT_W-1:0]      dma_desc_wb_count_o,
  output logic                  dma_desc_wb_busy_o,
  output logic                  dma_desc_wb_err_o,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      bytes_q, bytes_d;
  logic [31:0]      status_q, status_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic run;
  logic unused_ctrl;

  assign run         = csr_control_i[0];
  assign unused_ctrl = ^csr_control_i[31:1];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bytes_d  = bytes_q;
    status_d = status_q;
    count_d  = count_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (run && !wb.dma_desc_wb_fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        // Show-ahead FIFO: the head is valid in the same cycle as the pop.
        // A misaligned descriptor is flagged and written back to the
        // aligned base so the burst never straddles descriptors.
        addr_d   = {wb.dma_desc_wb_fifo_rddata[31:5], 5'b0};
        bytes_d  = wb.dma_desc_wb_fifo_rddata[63:32];
        status_d = wb.dma_desc_wb_fifo_rddata[95:64];
        if (wb.dma_desc_wb_fifo_rddata[4:0] != 5'd0) err_d = 1'b1;
        state_d  = ST_BEAT0;
      end
      ST_BEAT0: begin
        if (!wb.dma_desc_wb_waitrequest) state_d = ST_BEAT1;
      end
      ST_BEAT1: begin
        if (!wb.dma_desc_wb_waitrequest) state_d = ST_DONE;
      end
      ST_DONE: begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      bytes_q  <= '0;
      status_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bytes_q  <= bytes_d;
      status_q <= status_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  logic in_burst;
  assign in_burst = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);

  assign wb.dma_desc_wb_fifo_rd = (state_q == ST_POP);
  assign wb.dma_desc_wb_write   = in_burst;
  // Address and burstcount stay constant across both beats of the burst.
  assign wb.dma_desc_wb_addr    = in_burst ? (addr_q + WB_OFFSET) : 32'd0;
  assign wb.dma_desc_wb_bcount  = in_burst ? 4'd2 : 4'd0;
  assign wb.dma_desc_wb_wrdata  =
    (state_q == ST_BEAT0) ? bytes_q :
    (state_q == ST_BEAT1) ? (status_q & ~(32'h1 << OWN_BIT)) : 32'd0;

  assign dma_desc_wb_irq_o   = (state_q == ST_DONE) && status_q[IRQ_BIT];
  assign dma_desc_wb_count_o = count_q;
  assign dma_desc_wb_busy_o  = (state_q != ST_IDLE);
  assign dma_desc_wb_err_o   = err_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_dma_desc_writeback.sv
module tb_dma_desc_writeback;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [31:0]      ctrl;
  logic             irq;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             err;
  logic [2:0]       dbg_state;

  dma_desc_writeback_if wb_if ();

  dma_desc_writeback #(.CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .reset               (rst_n),
    .csr_control_i       (ctrl),
    .wb                  (wb_if),
    .dma_desc_wb_irq_o   (irq),
    .dma_desc_wb_count_o (count),
    .dma_desc_wb_busy_o  (busy),
    .dma_desc_wb_err_o   (err),
    .dbg_state_o         (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [95:0]      fifo_q[$];     // entries waiting in the write-back FIFO
  logic [31:0]      exp_addr_q[$]; // expected accepted beats, in order
  logic [31:0]      exp_q[$];      // expected writedata per beat
  logic             exp_irq_q[$];  // irq expectation per entry
  logic             exp_mis_q[$];  // entry was misaligned
  logic [CNT_W-1:0] exp_cnt;
  logic             err_exp;
  int               stall_n;       // waitrequest cycles before each beat is accepted
  int               stall_ctr;
  int               beat_idx;
  logic             pop_flag;
  logic             chk_done, chk_cnt, done_irq;
  int               busy_cycles;
  int               n_checks, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_entry(input logic [31:0] addr, input logic [31:0] bytes,
                            input logic [31:0] status);
    logic [31:0] base;
    base = {addr[31:5], 5'b0} + 32'h18;
    fifo_q.push_back({status, bytes, addr});
    exp_addr_q.push_back(base);
    exp_addr_q.push_back(base);
    exp_q.push_back(bytes);
    exp_q.push_back({1'b0, status[30:0]});
    exp_irq_q.push_back(status[30]);
    exp_mis_q.push_back(addr[4:0] != 5'd0);
  endtask

  // ---------------- compare / memory-side process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      wb_if.dma_desc_wb_waitrequest = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (pop_flag) begin
        void'(fifo_q.pop_front());
        pop_flag = 1'b0;
      end
      if (wb_if.dma_desc_wb_fifo_rd) begin
        chk("pop_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
        pop_flag = 1'b1;
      end
      if (chk_done) begin
        chk("irq_done", {31'd0, irq}, {31'd0, done_irq});
        chk("err_done", {31'd0, err}, {31'd0, err_exp});
        chk_done = 1'b0;
        chk_cnt  = 1'b1;
      end else begin
        chk("irq_quiet", {31'd0, irq}, 32'd0);
        if (chk_cnt) begin
          chk("count", {28'd0, count}, {28'd0, exp_cnt});
          chk_cnt = 1'b0;
        end
      end
      if (wb_if.dma_desc_wb_write) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
          wb_if.dma_desc_wb_waitrequest = 1'b0;
        end else begin
          chk("beat_addr", wb_if.dma_desc_wb_addr, exp_addr_q[0]);
          chk("beat_bcount", {28'd0, wb_if.dma_desc_wb_bcount}, 32'd2);
          chk("beat_data", wb_if.dma_desc_wb_wrdata, exp_q[0]);
          if (stall_ctr < stall_n) begin
            wb_if.dma_desc_wb_waitrequest = 1'b1;
            stall_ctr++;
          end else begin
            wb_if.dma_desc_wb_waitrequest = 1'b0;
            stall_ctr = 0;
            void'(exp_addr_q.pop_front());
            void'(exp_q.pop_front());
            if (beat_idx == 1) begin
              done_irq = exp_irq_q.pop_front();
              if (exp_mis_q.pop_front()) err_exp = 1'b1;
              exp_cnt  = exp_cnt + 1'b1;
              chk_done = 1'b1;
              beat_idx = 0;
            end else begin
              beat_idx = 1;
            end
          end
        end
      end else begin
        wb_if.dma_desc_wb_waitrequest = 1'b0;
      end
    end
    wb_if.dma_desc_wb_fifo_empty  = (fifo_q.size() == 0);
    wb_if.dma_desc_wb_fifo_rddata = (fifo_q.size() == 0) ? 96'd0 : fifo_q[0];
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(fifo_q.size() == 0 && !busy && exp_addr_q.size() == 0 &&
                 !chk_done && !chk_cnt && !pop_flag) && n < 3000);
    chk(name, {31'd0, n >= 3000}, 32'd0);
  endtask

  task automatic wait_cond_write(input string name, input int want_beat);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(wb_if.dma_desc_wb_write && beat_idx == want_beat) && n < 500);
    chk(name, {31'd0, n >= 500}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; ctrl = 32'd0;
    stall_n = 0; stall_ctr = 0; beat_idx = 0; pop_flag = 1'b0;
    chk_done = 1'b0; chk_cnt = 1'b0; done_irq = 1'b0;
    exp_cnt = '0; err_exp = 1'b0; busy_cycles = 0;
    n_checks = 0; n_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", {31'd0, wb_if.dma_desc_wb_write}, 32'd0);
    chk("rst_rd", {31'd0, wb_if.dma_desc_wb_fifo_rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_addr", wb_if.dma_desc_wb_addr, 32'd0);
    rst_n = 1'b1;
    ctrl  = 32'd1;

    // single entry, no stalls
    busy_cycles = 0;
    push_entry(32'h0000_1000, 32'h200, 32'hC000_0005);
    wait_idle("t1_idle");
    chk("t1_busy_cycles", busy_cycles, 32'd4);
    chk("t1_count", {28'd0, count}, 32'd1);

    // same entry, three waitrequest cycles on each beat
    stall_n = 3; busy_cycles = 0;
    push_entry(32'h0000_1000, 32'h200, 32'hC000_0005);
    wait_idle("t2_idle");
    chk("t2_busy_cycles", busy_cycles, 32'd10);
    stall_n = 0;

    // irq bit clear
    push_entry(32'h0000_3000, 32'h40, 32'h8000_0001);
    wait_idle("t3_idle");
    chk("t3_count", {28'd0, count}, 32'd3);

    // misaligned then aligned
    push_entry(32'h0000_2004, 32'h10, 32'h4000_0002);
    wait_idle("t4a_idle");
    chk("t4_err_set", {31'd0, err}, 32'd1);
    push_entry(32'h0000_4000, 32'h20, 32'h0000_0003);
    wait_idle("t4b_idle");
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    chk("t4_count", {28'd0, count}, 32'd5);

    // run dropped during BEAT0 of the first of three entries
    push_entry(32'h0000_5000, 32'h100, 32'hC000_0000);
    push_entry(32'h0000_5020, 32'h104, 32'h8000_0010);
    push_entry(32'h0000_5040, 32'h108, 32'hC000_0020);
    wait_cond_write("t5_reach_beat0", 0);
    ctrl = 32'd0;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_count_held", {28'd0, count}, 32'd6);
    chk("t5_fifo_left", fifo_q.size(), 32'd2);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    ctrl = 32'd1;
    wait_idle("t5_idle_all");
    chk("t5_count", {28'd0, count}, 32'd8);

    // reset asserted while BEAT1 is stalled
    stall_n = 100;
    push_entry(32'h0000_6000, 32'h44, 32'hC000_0009);
    wait_cond_write("t6_reach_beat1", 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_write", {31'd0, wb_if.dma_desc_wb_write}, 32'd0);
    chk("t6_count", {28'd0, count}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    exp_addr_q.delete(); exp_q.delete(); exp_irq_q.delete(); exp_mis_q.delete();
    stall_n = 0; stall_ctr = 0; beat_idx = 0; pop_flag = 1'b0;
    chk_done = 1'b0; chk_cnt = 1'b0; exp_cnt = '0; err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_state_idle", {29'd0, dbg_state}, 32'd0);
    push_entry(32'h0000_7000, 32'h8, 32'h4000_0000);
    wait_idle("t6_idle");
    chk("t6_count_after", {28'd0, count}, 32'd1);

    // fifteen more back-to-back entries: sixteenth completion wraps count
    for (int i = 0; i < 15; i++) begin
      push_entry(32'h0000_8000 + 32'(i) * 32'h20, 32'(i) * 32'd4,
                 (i % 2 == 1) ? (32'hC000_0000 | 32'(i)) : (32'h8000_0000 | 32'(i)));
    end
    wait_idle("t7_idle");
    chk("t7_count_wrap", {28'd0, count}, 32'd0);
    chk("t7_beats_left", exp_addr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
